updown_ctrl: RTL and testbench

Button-driven sequencer for the N-bit up/down counter (`counterUD`). It converts debounced up/down button levels into single-cycle `up`/`down` strobes, with press-and-hold auto-repeat, a two-button lockout, and optional saturation at configurable limits. It sits between the debounce/synchronizer stage and the counter; the counter's `o` is fed back as `cnt` for limit checks.

---
 rtl/updown_ctrl_pkg.sv | 20 ++
 rtl/hold_timer.sv | 27 ++
 rtl/updown_ctrl.sv | 119 +++++++++++
 tb/tb_updown_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/updown_ctrl_pkg.sv
// Shared definitions for the up/down button sequencer: FSM state encodings
// (also consumed by the status display) and timer sizing.
package updown_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    // Timer only has to reach max(hold, repeat) - 1.
    function automatic int unsigned timer_width(input int unsigned hold_dly,
                                                input int unsigned rpt_per);
        int unsigned m;
        m = (hold_dly > rpt_per) ? hold_dly : rpt_per;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Count-up timer with synchronous clear, count enable and a terminal-compare
// flag against a run-time selectable terminal value.
module hold_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 1'b1;
    end

    assign o_done = (r_count == i_term);

endmodule

// File: rtl/updown_ctrl.sv
// Button sequencer for counterUD: edge-triggered strobes, press-and-hold
// auto-repeat, two-button lockout and optional saturation at MIN/MAX.
module updown_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX      = 2**N - 1,
    parameter int unsigned MIN      = 0,
    parameter int unsigned WRAP     = 0,
    parameter int unsigned HOLD_DLY = 25_000_000,
    parameter int unsigned RPT_PER  = 5_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic [N-1:0] cnt,
    output logic         up_o,
    output logic         down_o,
    output logic         at_max,
    output logic         at_min,
    output logic [1:0]   state_o
);

    localparam int unsigned    TW        = timer_width(HOLD_DLY, RPT_PER);
    localparam logic [TW-1:0]  HOLD_TERM = TW'(HOLD_DLY - 1);
    localparam logic [TW-1:0]  RPT_TERM  = TW'(RPT_PER - 1);

    state_t        r_state, w_state_nx;
    logic          r_dir, w_dir_nx;
    logic          r_prev_up, r_prev_dn;
    logic          r_up_o, r_down_o;
    logic          w_rise_up, w_rise_dn;
    logic          w_held, w_other;
    logic          w_strobe, w_clr, w_en, w_done;
    logic          w_up_ok, w_dn_ok;
    logic [TW-1:0] w_term;

    assign w_rise_up = btn_up   & ~r_prev_up;
    assign w_rise_dn = btn_down & ~r_prev_dn;
    assign w_held    = r_dir ? btn_up   : btn_down;
    assign w_other   = r_dir ? btn_down : btn_up;
    assign w_term    = (r_state == S_REPEAT) ? RPT_TERM : HOLD_TERM;

    assign at_max  = (cnt == N'(MAX));
    assign at_min  = (cnt == N'(MIN));
    assign w_up_ok = (WRAP != 0) || !at_max;
    assign w_dn_ok = (WRAP != 0) || !at_min;

    hold_timer #(.W(TW)) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_term (w_term),
        .o_done (w_done)
    );

    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_dir;
        w_strobe   = 1'b0;
        w_clr      = 1'b1;
        w_en       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (btn_up && btn_down) begin
                    w_state_nx = S_LOCK;
                end else if (w_rise_up || w_rise_dn) begin
                    w_strobe   = 1'b1;
                    w_dir_nx   = w_rise_up;
                    w_state_nx = S_PRESS;
                end
            end
            S_PRESS, S_REPEAT: begin
                if (!w_held) begin
                    w_state_nx = S_IDLE;
                end else if (w_other) begin
                    w_state_nx = S_LOCK;
                end else if (w_done) begin
                    w_strobe   = 1'b1;
                    w_state_nx = S_REPEAT;
                end else begin
                    w_clr = 1'b0;
                    w_en  = 1'b1;
                end
            end
            S_LOCK: begin
                if (!btn_up && !btn_down)
                    w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Gating drops only the strobe; FSM and timer advance regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b1;
            r_prev_up <= 1'b1;
            r_prev_dn <= 1'b1;
            r_up_o    <= 1'b0;
            r_down_o  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_dir     <= w_dir_nx;
            r_prev_up <= btn_up;
            r_prev_dn <= btn_down;
            r_up_o    <= w_strobe &  w_dir_nx & w_up_ok;
            r_down_o  <= w_strobe & ~w_dir_nx & w_dn_ok;
        end
    end

    assign up_o    = r_up_o;
    assign down_o  = r_down_o;
    assign state_o = r_state;

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed bench for updown_ctrl driving a behavioural 4-bit up/down counter.
module tb_updown_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       bu, bd;
    logic       ld;
    logic [3:0] ld_val;
    logic [3:0] cnt;
    logic       up_o, down_o, at_max, at_min;
    logic [1:0] state_o;

    logic       bu2, bd2;
    logic [3:0] cnt2;
    logic       up2, dn2, amx2, amn2;
    logic [1:0] st2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    updown_ctrl #(.N(4), .MAX(9), .MIN(0), .WRAP(0), .HOLD_DLY(8), .RPT_PER(4)) dut (
        .clk(clk), .rst(rst), .btn_up(bu), .btn_down(bd), .cnt(cnt),
        .up_o(up_o), .down_o(down_o), .at_max(at_max), .at_min(at_min), .state_o(state_o)
    );

    updown_ctrl #(.N(4), .MAX(9), .MIN(0), .WRAP(1), .HOLD_DLY(8), .RPT_PER(4)) dut_wrap (
        .clk(clk), .rst(rst), .btn_up(bu2), .btn_down(bd2), .cnt(cnt2),
        .up_o(up2), .down_o(dn2), .at_max(amx2), .at_min(amn2), .state_o(st2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (ld)      cnt <= ld_val;
        else if (up_o)    cnt <= cnt + 4'd1;
        else if (down_o)  cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt2 <= '0;
        else if (up2)     cnt2 <= cnt2 + 4'd1;
        else if (dn2)     cnt2 <= cnt2 - 4'd1;
    end

    typedef struct {
        logic       bu, bd;
        logic       up, dn;
        logic [1:0] st;
        logic [3:0] c;
    } vec_t;

    function automatic vec_t mk(input int b_u, input int b_d, input int e_up,
                                input int e_dn, input int e_st, input int e_c);
        vec_t v;
        v.bu = b_u[0];  v.bd = b_d[0];
        v.up = e_up[0]; v.dn = e_dn[0];
        v.st = e_st[1:0];
        v.c  = e_c[3:0];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] v);
        ld_val = v;
        ld     = 1'b1;
        step();
        ld     = 1'b0;
        step();
    endtask

    vec_t vt[21];

    initial begin
        // single press, then hold up and lock with down, then a lone down press
        vt[0]  = mk(0,0, 0,0, 0, 0);
        vt[1]  = mk(0,0, 0,0, 0, 0);
        vt[2]  = mk(1,0, 1,0, 1, 0);
        vt[3]  = mk(1,0, 0,0, 1, 1);
        vt[4]  = mk(1,0, 0,0, 1, 1);
        vt[5]  = mk(0,0, 0,0, 0, 1);
        vt[6]  = mk(0,0, 0,0, 0, 1);
        vt[7]  = mk(1,0, 1,0, 1, 1);
        vt[8]  = mk(1,0, 0,0, 1, 2);
        vt[9]  = mk(1,0, 0,0, 1, 2);
        vt[10] = mk(1,1, 0,0, 3, 2);
        vt[11] = mk(1,1, 0,0, 3, 2);
        vt[12] = mk(1,0, 0,0, 3, 2);
        vt[13] = mk(1,0, 0,0, 3, 2);
        vt[14] = mk(1,0, 0,0, 3, 2);
        vt[15] = mk(1,0, 0,0, 3, 2);
        vt[16] = mk(1,0, 0,0, 3, 2);
        vt[17] = mk(0,0, 0,0, 0, 2);
        vt[18] = mk(0,1, 0,1, 1, 2);
        vt[19] = mk(0,0, 0,0, 0, 1);
        vt[20] = mk(0,0, 0,0, 0, 1);

        rst = 1'b1; bu = 1'b0; bd = 1'b0; bu2 = 1'b0; bd2 = 1'b0;
        ld = 1'b0; ld_val = '0;
        #2;
        chk("reset up_o", {31'd0, up_o}, 32'd0);
        chk("reset down_o", {31'd0, down_o}, 32'd0);
        chk("reset state", {30'd0, state_o}, 32'd0);
        step(); step();
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            bu = vt[i].bu;
            bd = vt[i].bd;
            step();
            chk($sformatf("vec%0d up_o", i),  {31'd0, up_o},    {31'd0, vt[i].up});
            chk($sformatf("vec%0d down_o", i), {31'd0, down_o}, {31'd0, vt[i].dn});
            chk($sformatf("vec%0d state", i), {30'd0, state_o}, {30'd0, vt[i].st});
            chk($sformatf("vec%0d cnt", i),   {28'd0, cnt},     {28'd0, vt[i].c});
        end

        // hold up 20 cycles from 0: strobes at offsets 0, 8, 12, 16
        load(4'd0);
        bu = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("hold off%0d up_o", i), {31'd0, up_o},
                (i == 0 || i == 8 || i == 12 || i == 16) ? 32'd1 : 32'd0);
        end
        bu = 1'b0;
        step();
        chk("hold release up_o", {31'd0, up_o}, 32'd0);
        chk("hold release state", {30'd0, state_o}, 32'd0);
        step();
        chk("hold final cnt", {28'd0, cnt}, 32'd4);

        // saturation at MAX from 8
        load(4'd8);
        bu = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            chk($sformatf("sat off%0d up_o", i), {31'd0, up_o}, (i == 0) ? 32'd1 : 32'd0);
        end
        chk("sat state", {30'd0, state_o}, 32'd2);
        chk("sat cnt", {28'd0, cnt}, 32'd9);
        chk("sat at_max", {31'd0, at_max}, 32'd1);
        bu = 1'b0;
        step(); step();

        // saturation at MIN, then wrap instance
        load(4'd0);
        bd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("min off%0d down_o", i), {31'd0, down_o}, 32'd0);
        end
        chk("min at_min", {31'd0, at_min}, 32'd1);
        chk("min cnt", {28'd0, cnt}, 32'd0);
        bd = 1'b0;
        bd2 = 1'b1;
        step();
        chk("wrap down_o", {31'd0, dn2}, 32'd1);
        step();
        chk("wrap down_o off1", {31'd0, dn2}, 32'd0);
        chk("wrap cnt", {28'd0, cnt2}, 32'd15);
        bd2 = 1'b0;
        step(); step();

        // button held through reset release issues nothing
        bu = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("rsthold off%0d up_o", i), {31'd0, up_o}, 32'd0);
        end
        chk("rsthold state", {30'd0, state_o}, 32'd0);
        bu = 1'b0;
        step(); step();

        // async reset during REPEAT while a strobe is high
        bu = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step();
            chk($sformatf("rpt off%0d up_o", i), {31'd0, up_o},
                (i == 0 || i == 8 || i == 12) ? 32'd1 : 32'd0);
        end
        chk("rpt state", {30'd0, state_o}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst up_o", {31'd0, up_o}, 32'd0);
        chk("async rst state", {30'd0, state_o}, 32'd0);
        bu = 1'b0;
        step();
        rst = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
